cop0_exception_recorder: RTL and testbench

Coprocessor-0 state block for the MIPS pipeline. It consumes the per-cycle exception record from the exception controller and commits it into the architectural COP0 registers: Status, Cause, EPC, BadVAddr, Count, Compare and EBase. It also handles ERET, MTC0/MFC0 accesses, interrupt sampling and the interrupt request back to the pipeline. It sits in the memory stage and feeds the `cop0excreg` bundle carried down the pipeline.

---
 rtl/cop0_exception_recorder.sv | 209 ++++++++++++++++++++
 tb/tb_cop0_exception_recorder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_exception_recorder.sv
// COP0 architectural state for the memory stage: Status, Cause, EPC,
// BadVAddr, EBase and (optionally) Count/Compare with the timer interrupt.
// Optional feature macro: COP0_TIMER_INT_EN enables Count/Compare and TI.
// Same-cycle priority: exception > ERET > MTC0; a dropped event has no effect.

package cop0_info;
  typedef struct packed {
    logic        exception_happen;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        in_bd;
    logic        load_addr;
    logic [31:0] badvaddr;
  } cop0_exc_data_t;
endpackage

module cop0_exception_recorder #(
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cop0_info::cop0_exc_data_t  exc_data,
  input  logic                       eret,
  input  logic                       we,
  input  logic [4:0]                 waddr,
  input  logic [2:0]                 wsel,
  input  logic [31:0]                wdata,
  input  logic [4:0]                 raddr,
  input  logic [2:0]                 rsel,
  output logic [31:0]                rdata,
  input  logic [5:0]                 hw_int,
  output logic [31:0]                status_o,
  output logic [31:0]                cause_o,
  output logic [31:0]                epc_o,
  output logic [31:0]                badvaddr_o,
  output logic [31:0]                ebase_o,
  output logic [31:0]                eret_target,
  output logic                       int_req
);

  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] A_EBASE    = {5'd15, 3'd1};

  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF17;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  localparam int unsigned ERL = 2;
  localparam int unsigned EXL = 1;
  localparam int unsigned IE  = 0;

  logic [31:0] status, status_next;
  logic [31:0] cause, cause_next;
  logic [31:0] epc, epc_next;
  logic [31:0] badvaddr, badvaddr_next;
  logic [31:0] ebase, ebase_next;
  logic        ti_next;

  logic       exc;
  logic       eret_ok;
  logic       mtc0_ok;
  logic [7:0] wa;
  logic       wr_status, wr_cause, wr_epc, wr_ebase;

  assign exc     = exc_data.exception_happen;
  assign eret_ok = eret & ~exc;
  assign mtc0_ok = we & ~exc & ~eret;
  assign wa      = {waddr, wsel};

  assign wr_status = mtc0_ok && (wa == A_STATUS);
  assign wr_cause  = mtc0_ok && (wa == A_CAUSE);
  assign wr_epc    = mtc0_ok && (wa == A_EPC);
  assign wr_ebase  = mtc0_ok && (wa == A_EBASE);

`ifdef COP0_TIMER_INT_EN
  logic [31:0] count, count_next;
  logic [31:0] compare, compare_next;
  logic [31:0] count_inc;
  logic        tick;
  logic        wr_count, wr_compare;

  assign wr_count   = mtc0_ok && (wa == A_COUNT);
  assign wr_compare = mtc0_ok && (wa == A_COMPARE);
  assign count_inc  = count + 32'd1;

  // Count/Compare next state and timer interrupt flag; the match is only
  // evaluated on increment edges that are not overridden by a Count write,
  // and a Compare write always leaves TI clear.
  always_comb begin
    count_next   = count;
    compare_next = compare;
    ti_next      = cause[30];
    if (wr_count) begin
      count_next = wdata;
    end else if (tick) begin
      count_next = count_inc;
      if (count_inc == compare) ti_next = 1'b1;
    end
    if (wr_compare) begin
      compare_next = wdata;
      ti_next      = 1'b0;
    end
  end

  // Timer state registers; tick halves the clock for Count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
    end else begin
      count   <= count_next;
      compare <= compare_next;
      tick    <= ~tick;
    end
  end
`else
  assign ti_next = 1'b0;
`endif

  // Status: exception sets EXL, ERET clears ERL first then EXL, MTC0 masked.
  always_comb begin
    status_next = status;
    if (exc) begin
      status_next[EXL] = 1'b1;
    end else if (eret_ok) begin
      if (status[ERL]) status_next[ERL] = 1'b0;
      else             status_next[EXL] = 1'b0;
    end else if (wr_status) begin
      status_next = (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
    end
  end

  // Cause: exception record, software IP writes, and per-cycle IP sampling.
  always_comb begin
    cause_next = cause;
    if (exc) begin
      if (!status[EXL]) cause_next[31] = exc_data.in_bd;
      cause_next[6:2] = exc_data.exc_code;
    end else if (wr_cause) begin
      cause_next[9:8] = wdata[9:8];
    end
    cause_next[30]    = ti_next;
    cause_next[15:10] = {hw_int[5] | ti_next, hw_int[4:0]};
  end

  // EPC, BadVAddr and EBase next values.
  always_comb begin
    epc_next      = epc;
    badvaddr_next = badvaddr;
    ebase_next    = ebase;
    if (exc) begin
      if (!status[EXL])       epc_next      = exc_data.epc;
      if (exc_data.load_addr) badvaddr_next = exc_data.badvaddr;
    end else begin
      if (wr_epc)   epc_next   = wdata;
      if (wr_ebase) ebase_next = (ebase & ~EBASE_WMASK) | (wdata & EBASE_WMASK);
    end
  end

  // Architectural register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      status   <= STATUS_RESET;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
      ebase    <= EBASE_RESET;
    end else begin
      status   <= status_next;
      cause    <= cause_next;
      epc      <= epc_next;
      badvaddr <= badvaddr_next;
      ebase    <= ebase_next;
    end
  end

  // MFC0 read mux from current (pre-edge) register values.
  always_comb begin
    rdata = '0;
    case ({raddr, rsel})
      A_BADVADDR: rdata = badvaddr;
`ifdef COP0_TIMER_INT_EN
      A_COUNT:    rdata = count;
      A_COMPARE:  rdata = compare;
`endif
      A_STATUS:   rdata = status;
      A_CAUSE:    rdata = cause;
      A_EPC:      rdata = epc;
      A_EBASE:    rdata = ebase;
      default:    rdata = '0;
    endcase
  end

  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign badvaddr_o  = badvaddr;
  assign ebase_o     = ebase;
  assign eret_target = epc;
  assign int_req     = status[IE] & ~status[EXL] & ~status[ERL] &
                       (|(status[15:8] & cause[15:8]));

endmodule

// File: tb/tb_cop0_exception_recorder.sv
// Directed bench for cop0_exception_recorder with a queue-based scoreboard.
// Expected values are pushed while stimulus is set up and checked after the edge.
module tb_cop0_exception_recorder;

  logic                      clk = 1'b0;
  logic                      reset;
  cop0_info::cop0_exc_data_t exc_data;
  logic                      eret;
  logic                      we;
  logic [4:0]                waddr;
  logic [2:0]                wsel;
  logic [31:0]               wdata;
  logic [4:0]                raddr;
  logic [2:0]                rsel;
  logic [31:0]               rdata;
  logic [5:0]                hw_int;
  logic [31:0]               status_o, cause_o, epc_o, badvaddr_o, ebase_o, eret_target;
  logic                      int_req;

  cop0_exception_recorder #(.EBASE_RESET(32'h8000_0000)) dut (
    .clk(clk), .reset(reset), .exc_data(exc_data), .eret(eret),
    .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata), .hw_int(hw_int),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .badvaddr_o(badvaddr_o), .ebase_o(ebase_o),
    .eret_target(eret_target), .int_req(int_req)
  );

  always #5 clk = ~clk;

  int run_edges = 0;
  always @(posedge clk) begin
    if (reset) run_edges <= 0;
    else       run_edges <= run_edges + 1;
  end

  localparam int S_STATUS = 0, S_CAUSE = 1, S_EPC = 2, S_BADV = 3,
                 S_EBASE = 4, S_RDATA = 5, S_ERET = 6, S_INT = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_STATUS: return status_o;
      S_CAUSE:  return cause_o;
      S_EPC:    return epc_o;
      S_BADV:   return badvaddr_o;
      S_EBASE:  return ebase_o;
      S_RDATA:  return rdata;
      S_ERET:   return eret_target;
      S_INT:    return {31'd0, int_req};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // One clock edge, then compare every queued expectation against the DUT.
  task automatic step();
    sb_entry_t e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    exc_data = '0;
    eret = 1'b0;
    we = 1'b0;
    waddr = '0;
    wsel = '0;
    wdata = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = s; wdata = d;
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic ld, input logic [31:0] bva);
    exc_data.exception_happen = 1'b1;
    exc_data.exc_code = code;
    exc_data.epc = pc;
    exc_data.in_bd = bd;
    exc_data.load_addr = ld;
    exc_data.badvaddr = bva;
  endtask

  initial begin
    reset = 1'b1;
    hw_int = '0;
    raddr = 5'd12; rsel = 3'd0;
    idle();
    step();
    push("rst_status", S_STATUS, 32'h0040_0004);
    push("rst_cause",  S_CAUSE,  32'h0000_0000);
    push("rst_epc",    S_EPC,    32'h0000_0000);
    push("rst_badv",   S_BADV,   32'h0000_0000);
    push("rst_ebase",  S_EBASE,  32'h8000_0000);
    push("rst_int",    S_INT,    32'd0);
    push("rst_rd_status", S_RDATA, 32'h0040_0004);
    step();
    reset = 1'b0;

    // Enable interrupts with IP2 pending.
    hw_int = 6'b000001;
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    push("ie_status", S_STATUS, 32'h0000_FF01);
    push("ie_cause",  S_CAUSE,  32'h0000_0400);
    push("ie_int",    S_INT,    32'd1);
    step();
    idle();

    // First exception with EXL=0.
    set_exc(5'h4, 32'hBFC0_0010, 1'b1, 1'b1, 32'h0000_1001);
    push("exc1_epc",    S_EPC,    32'hBFC0_0010);
    push("exc1_cause",  S_CAUSE,  32'h8000_0410);
    push("exc1_badv",   S_BADV,   32'h0000_1001);
    push("exc1_status", S_STATUS, 32'h0000_FF03);
    push("exc1_int",    S_INT,    32'd0);
    step();
    idle();

    // Nested exception with EXL=1.
    set_exc(5'hC, 32'h1234_5678, 1'b0, 1'b0, 32'hFFFF_FFFF);
    push("exc2_epc",   S_EPC,   32'hBFC0_0010);
    push("exc2_cause", S_CAUSE, 32'h8000_0430);
    push("exc2_badv",  S_BADV,  32'h0000_1001);
    step();
    idle();

    // ERET clears ERL first, then EXL.
    mtc0(5'd12, 3'd0, 32'h0000_FF07);
    push("erl_set", S_STATUS, 32'h0000_FF07);
    step();
    idle();
    eret = 1'b1;
    push("eret1_status", S_STATUS, 32'h0000_FF03);
    push("eret1_target", S_ERET,   32'hBFC0_0010);
    step();
    push("eret2_status", S_STATUS, 32'h0000_FF01);
    push("eret2_target", S_ERET,   32'hBFC0_0010);
    push("eret2_int",    S_INT,    32'd1);
    step();
    idle();

    // Exception, ERET and MTC0 EPC together: only the exception lands.
    set_exc(5'h5, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    eret = 1'b1;
    mtc0(5'd14, 3'd0, 32'h0000_0000);
    push("prio_epc",    S_EPC,    32'h0000_0100);
    push("prio_status", S_STATUS, 32'h0000_FF03);
    push("prio_cause",  S_CAUSE,  32'h0000_0414);
    step();
    idle();
    eret = 1'b1;
    push("prio_eret", S_STATUS, 32'h0000_FF01);
    step();
    idle();

    // EBase writable field and read-back by sel.
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    raddr = 5'd15; rsel = 3'd1;
    push("ebase_o",  S_EBASE, 32'hBFFF_F000);
    push("ebase_rd", S_RDATA, 32'hBFFF_F000);
    step();
    idle();
    rsel = 3'd0;
    push("unmapped_rd", S_RDATA, 32'h0000_0000);
    step();

    // Cause software IP only; BadVAddr is read-only.
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    push("cause_sw", S_CAUSE, 32'h0000_0714);
    step();
    mtc0(5'd8, 3'd0, 32'h0000_0000);
    raddr = 5'd8;
    push("badv_ro", S_RDATA, 32'h0000_1001);
    step();
    idle();

    // IP7 follows hw_int[5].
    hw_int = 6'b100000;
    push("ip7_cause", S_CAUSE, 32'h0000_8314);
    push("ip7_int",   S_INT,   32'd1);
    step();

    // Mid-operation reset overrides a concurrent write and exception.
    reset = 1'b1;
    mtc0(5'd14, 3'd0, 32'hAAAA_AAAA);
    set_exc(5'h3, 32'h5555_5555, 1'b1, 1'b1, 32'h7777_7777);
    push("mrst_status", S_STATUS, 32'h0040_0004);
    push("mrst_cause",  S_CAUSE,  32'h0000_0000);
    push("mrst_epc",    S_EPC,    32'h0000_0000);
    push("mrst_badv",   S_BADV,   32'h0000_0000);
    push("mrst_ebase",  S_EBASE,  32'h8000_0000);
    push("mrst_int",    S_INT,    32'd0);
    step();
    reset = 1'b0;
    idle();
    hw_int = '0;
    step();

`ifdef COP0_TIMER_INT_EN
    // Align so the Count write lands on an increment edge.
    if ((run_edges % 2) == 0) step();
    mtc0(5'd9, 3'd0, 32'h0000_0000);
    step();
    mtc0(5'd11, 3'd0, 32'h0000_0010);
    step();
    idle();
    for (int i = 0; i < 29; i++) step();
    raddr = 5'd9; rsel = 3'd0;
    push("tmr_pre_cause", S_CAUSE, 32'h0000_0000);
    push("tmr_pre_count", S_RDATA, 32'h0000_000F);
    step();
    push("tmr_hit_cause", S_CAUSE, 32'h4000_8000);
    push("tmr_hit_count", S_RDATA, 32'h0000_0010);
    step();
    mtc0(5'd11, 3'd0, 32'h0000_0010);
    raddr = 5'd11;
    push("tmr_clr_cause", S_CAUSE, 32'h0000_0000);
    push("tmr_compare",   S_RDATA, 32'h0000_0010);
    step();
    idle();
`else
    mtc0(5'd9, 3'd0, 32'h0000_1234);
    raddr = 5'd9; rsel = 3'd0;
    push("no_tmr_count", S_RDATA, 32'h0000_0000);
    step();
    mtc0(5'd11, 3'd0, 32'h0000_0005);
    raddr = 5'd11;
    push("no_tmr_compare", S_RDATA, 32'h0000_0000);
    step();
    idle();
    for (int i = 0; i < 40; i++) step();
    push("no_tmr_ti", S_CAUSE, 32'h0000_0000);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
